// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the memory port arbiter.
//   state_t  : arbiter FSM state encoding (IDLE, ACCESS, DONE)
//   GNT_IF/D : grantee encoding (instruction fetch / data access)
//   CNT_W    : width of the memory latency counter
package mem_arb_pkg;
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;
    localparam logic GNT_IF = 1'b0;
    localparam logic GNT_D  = 1'b1;
    localparam int   CNT_W  = 4;
endpackage

// File: rtl/mem_lat_timer.sv
// mem_lat_timer: loadable down-counter that tracks cycles until read data is valid.
//   clk   : system clock
//   reset : synchronous active-low reset, clears the count
//   load  : load value into the counter (has priority over counting)
//   value : count to load
//   zero  : high while the count is zero
module mem_lat_timer
    import mem_arb_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         zero
);
    logic [W-1:0] cnt;

    // Counts down once per cycle and parks at zero.
    always_ff @(posedge clk) begin
        if (!reset) cnt <= '0;
        else if (load) cnt <= value;
        else if (cnt != '0) cnt <= cnt - 1'b1;
    end

    assign zero = (cnt == '0);
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency memory port between IF fetch and MEM data access.
//   clk, reset          : clock, synchronous active-low reset
//   if_req/if_addr      : fetch request and address; if_rdata/if_ready return the instruction
//   d_req/d_we/d_addr/
//   d_wdata             : data request; d_rdata/d_ready return load data / completion
//   mem_en/mem_we/
//   mem_addr/mem_wdata  : registered memory strobe, write enable, address, store data
//   mem_rdata           : memory read data, valid MEM_LAT cycles after mem_en
//   pipe_stall          : freezes the pipeline while any request is unanswered
//   busy                : an access is in progress
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              pipe_stall,
    output logic              busy
);
    if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_bad_lat
        $error("mem_port_arbiter: MEM_LAT must be in 1..15");
    end

    state_t state, state_n;
    logic   gnt, last_was_d, grant_d, start, fin, zero;

    mem_lat_timer #(.W(CNT_W)) u_timer (
        .clk   (clk),
        .reset (reset),
        .load  (start),
        .value (CNT_W'(MEM_LAT)),
        .zero  (zero)
    );

    always_ff @(posedge clk) begin
        state <= !reset ? IDLE : state_n;
    end

    // Data wins a tie unless it won last time, so a stream of stores cannot starve fetch.
    always_comb begin
        grant_d = d_req & (~if_req | ~last_was_d);
        start   = (state == IDLE) & (if_req | d_req);
        fin     = (state == ACCESS) & zero;
        state_n = state == IDLE   ? (start ? ACCESS : IDLE) :
                  state == ACCESS ? (zero ? DONE : ACCESS) : IDLE;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            if_rdata   <= '0;
            d_rdata    <= '0;
            if_ready   <= 1'b0;
            d_ready    <= 1'b0;
            gnt        <= GNT_IF;
            last_was_d <= 1'b0;
        end else begin
            mem_en   <= start;
            if_ready <= fin & (gnt == GNT_IF);
            d_ready  <= fin & (gnt == GNT_D);
            if (start) begin
                mem_addr   <= grant_d ? d_addr : if_addr;
                mem_we     <= grant_d & d_we;
                mem_wdata  <= grant_d ? d_wdata : '0;
                gnt        <= grant_d ? GNT_D : GNT_IF;
                last_was_d <= grant_d;
            end
            if (fin && gnt == GNT_IF) if_rdata <= mem_rdata;
            if (fin && gnt == GNT_D && !mem_we) d_rdata <= mem_rdata;
        end
    end

    assign pipe_stall = (if_req & ~if_ready) | (d_req & ~d_ready);
    assign busy       = (state != IDLE);
endmodule
